data_unpack_8to16: RTL and testbench

//   Receive-side counterpart of the RAW8 packer. Accepts a RAW8 AXI4-Stream byte frame
//   (little endian, TUSER on byte 0, TLAST on the final byte) and rebuilds 16-bit words:
//   {byte[2k+1], byte[2k]} = word k. Sits between the loopback/DMA read path and
//   16-bit consumers. Checks frame structure and flags framing errors.

---
 rtl/raw8_pkg.sv | 15 +
 rtl/data_unpack_8to16.sv | 142 ++++++++++++++
 tb/tb_data_unpack_8to16.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raw8_pkg.sv
// RAW8 framing constants and FSM state encoding.
// Shared by the RAW8 packer, the unpacker and their benches.
package raw8_pkg;

  localparam int RAW8_WORD_COUNT = 256;
  localparam int RAW8_BYTE_COUNT = 512;
  localparam int RAW8_ALIGN      = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LSB  = 2'd1,
    ST_MSB  = 2'd2
  } raw8_state_t;

endpackage

// File: rtl/data_unpack_8to16.sv
// RAW8 byte stream to 16-bit word unpacker.
// Rebuilds little-endian words and flags framing errors.
module data_unpack_8to16
  import raw8_pkg::*;
#(
  parameter int WORD_COUNT = RAW8_WORD_COUNT,
  parameter int BYTE_COUNT = RAW8_BYTE_COUNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        m_user,
  output logic        err_short,
  output logic        err_long,
  output logic        err_sof,
  output logic        frame_done
);

  localparam int CW = $clog2(BYTE_COUNT) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTE_COUNT - 1);

  if (BYTE_COUNT != 2 * WORD_COUNT ||
      BYTE_COUNT % RAW8_ALIGN != 0) begin : g_bad_cfg
    $error("data_unpack_8to16: bad BYTE_COUNT/WORD_COUNT");
  end

  raw8_state_t   state;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    lsb_reg;
  logic          first_word;
  logic          out_free;
  logic          acc;

  assign out_free = !m_valid || m_ready;
  assign acc      = s_axis_tvalid && s_axis_tready;

  // IDLE always accepts so stray bytes get dropped instead of stalling.
  always_comb begin
    s_axis_tready = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE:        s_axis_tready = 1'b1;
        ST_LSB, ST_MSB: s_axis_tready = out_free;
        default:        s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      lsb_reg    <= '0;
      first_word <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_user     <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_sof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_sof    <= 1'b0;
      frame_done <= 1'b0;
      if (m_ready) m_valid <= 1'b0;
      if (acc) begin
        unique case (state)
          ST_IDLE: begin
            if (!s_axis_tuser) begin
              err_sof <= 1'b1;
            end else if (s_axis_tlast) begin
              m_valid    <= 1'b1;
              m_data     <= {8'h00, s_axis_tdata};
              m_last     <= 1'b1;
              m_user     <= 1'b1;
              err_short  <= 1'b1;
              frame_done <= 1'b1;
            end else begin
              lsb_reg    <= s_axis_tdata;
              byte_cnt   <= CW'(1);
              first_word <= 1'b1;
              state      <= ST_MSB;
            end
          end
          ST_LSB: begin
            if (s_axis_tuser) err_sof <= 1'b1;
            if (s_axis_tlast) begin
              // odd-length frame: pad the lone byte
              m_valid    <= 1'b1;
              m_data     <= {8'h00, s_axis_tdata};
              m_last     <= 1'b1;
              m_user     <= s_axis_tuser;
              err_short  <= 1'b1;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              lsb_reg <= s_axis_tdata;
              state   <= ST_MSB;
              if (s_axis_tuser) begin
                byte_cnt   <= CW'(1);
                first_word <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + CW'(1);
              end
            end
          end
          ST_MSB: begin
            m_valid    <= 1'b1;
            m_data     <= {s_axis_tdata, lsb_reg};
            m_user     <= first_word;
            first_word <= 1'b0;
            byte_cnt   <= byte_cnt + CW'(1);
            if (s_axis_tuser) err_sof <= 1'b1;
            if (byte_cnt == LAST_IDX || s_axis_tlast) begin
              m_last     <= 1'b1;
              frame_done <= 1'b1;
              err_long   <= !s_axis_tlast;
              err_short  <= s_axis_tlast && (byte_cnt != LAST_IDX);
              state      <= ST_IDLE;
            end else begin
              m_last <= 1'b0;
              state  <= ST_LSB;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_unpack_8to16.sv
// Randomized bench for data_unpack_8to16.
// Expected words come from a byte-pairing model of the frame.
module tb_data_unpack_8to16;
  import raw8_pkg::*;

  localparam int BC = RAW8_BYTE_COUNT;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tuser;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_user;
  logic        err_short;
  logic        err_long;
  logic        err_sof;
  logic        frame_done;

  data_unpack_8to16 dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .s_axis_tuser  (tuser),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .m_user        (m_user),
    .err_short     (err_short),
    .err_long      (err_long),
    .err_sof       (err_sof),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int ready_pct = 100;
  int gap_pct = 0;
  int timeouts = 0;
  int n_short, n_long, n_sof, n_done, stall_viol;
  logic        prev_stall;
  logic [17:0] held;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic [7:0]  fb[$];

  // sink side: random backpressure
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // monitor: handshakes, pulses, and hold-while-stalled
  initial begin
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall &&
            (!m_valid || {m_last, m_user, m_data} !== held))
          stall_viol++;
        if (m_valid && m_ready)
          got_q.push_back({m_last, m_user, m_data});
        if (err_short) n_short++;
        if (err_long) n_long++;
        if (err_sof) n_sof++;
        if (frame_done) n_done++;
        prev_stall = m_valid && !m_ready;
        held = {m_last, m_user, m_data};
      end
    end
  end

  task automatic clear_sb();
    got_q.delete();
    n_short = 0;
    n_long = 0;
    n_sof = 0;
    n_done = 0;
    stall_viol = 0;
    timeouts = 0;
    prev_stall = 1'b0;
  endtask

  task automatic fill(input int n, input bit ramp);
    fb.delete();
    for (int i = 0; i < n; i++)
      fb.push_back(ramp ? 8'(i) : 8'($urandom));
  endtask

  // pair bytes little-endian; a lone tail byte is zero-padded
  task automatic build_expected(input int n_keep);
    int nw;
    logic [7:0] hi;
    exp_q.delete();
    nw = (n_keep + 1) / 2;
    for (int k = 0; k < nw; k++) begin
      hi = (2 * k + 1 < n_keep) ? fb[2 * k + 1] : 8'h00;
      exp_q.push_back({k == nw - 1, k == 0, hi, fb[2 * k]});
    end
  endtask

  function automatic int word_errs();
    int e = 0;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      if (got_q[k] !== exp_q[k]) e++;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] d,
                           input logic u, input logic l);
    int n;
    while ($urandom_range(0, 99) < gap_pct) begin
      tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    tvalid = 1'b1;
    tdata = d;
    tuser = u;
    tlast = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (tready) break;
      n++;
      if (n > 2000) begin
        timeouts++;
        break;
      end
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tuser = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic send_frame(input int last_idx);
    for (int i = 0; i < fb.size(); i++)
      send_byte(fb[i], i == 0, i == last_idx);
  endtask

  task automatic drain();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) timeouts++;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({tready, m_valid, m_data, m_last, m_user, err_short,
         err_long, err_sof, frame_done} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b d=%h tr=%b want all 0",
               m_valid, m_data, tready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_tready: got %b want 1", tready);
    end
  endtask

  task automatic test_full_frame();
    ready_pct = 100;
    gap_pct = 0;
    clear_sb();
    fill(BC, 1'b1);
    build_expected(BC);
    send_frame(BC - 1);
    drain();
    tests_run++;
    if (got_q.size() !== 256) begin
      tests_failed++;
      $display("FAIL full_count: got %0d want 256", got_q.size());
    end
    tests_run++;
    if (word_errs() !== 0) begin
      tests_failed++;
      $display("FAIL full_words: got %0d bad want 0", word_errs());
    end
    if (got_q.size() == 256) begin
      tests_run++;
      if (got_q[0] !== 18'h10100 || got_q[255] !== 18'h2fffe) begin
        tests_failed++;
        $display("FAIL full_ends: got %h %h want 10100 2fffe",
                 got_q[0], got_q[255]);
      end
    end
    tests_run++;
    if ({n_short, n_long, n_sof, n_done, timeouts} !== {32'd0, 32'd0,
        32'd0, 32'd1, 32'd0}) begin
      tests_failed++;
      $display("FAIL full_flags: got s=%0d l=%0d sof=%0d done=%0d to=%0d want 0 0 0 1 0",
               n_short, n_long, n_sof, n_done, timeouts);
    end
  endtask

  task automatic test_stall();
    ready_pct = 50;
    gap_pct = 30;
    clear_sb();
    fill(BC, 1'b1);
    build_expected(BC);
    send_frame(BC - 1);
    drain();
    tests_run++;
    if (got_q.size() !== 256 || word_errs() !== 0) begin
      tests_failed++;
      $display("FAIL stall_words: got n=%0d bad=%0d want 256 0",
               got_q.size(), word_errs());
    end
    tests_run++;
    if (stall_viol !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d changes want 0", stall_viol);
    end
    tests_run++;
    if ({n_short, n_long, n_sof, n_done, timeouts} !== {32'd0, 32'd0,
        32'd0, 32'd1, 32'd0}) begin
      tests_failed++;
      $display("FAIL stall_flags: got s=%0d l=%0d sof=%0d done=%0d to=%0d want 0 0 0 1 0",
               n_short, n_long, n_sof, n_done, timeouts);
    end
  endtask

  task automatic test_next_ok(input string tag);
    clear_sb();
    fill(BC, 1'b0);
    build_expected(BC);
    send_frame(BC - 1);
    drain();
    tests_run++;
    if (got_q.size() !== 256 || word_errs() !== 0 ||
        n_short + n_long + n_sof !== 0 || timeouts !== 0) begin
      tests_failed++;
      $display("FAIL %s_next: got n=%0d bad=%0d errs=%0d want 256 0 0",
               tag, got_q.size(), word_errs(), n_short + n_long + n_sof);
    end
  endtask

  task automatic test_short(input int len);
    ready_pct = 70;
    gap_pct = 10;
    clear_sb();
    fill(len, 1'b0);
    build_expected(len);
    send_frame(len - 1);
    drain();
    tests_run++;
    if (got_q.size() !== (len + 1) / 2 || word_errs() !== 0) begin
      tests_failed++;
      $display("FAIL short%0d_words: got n=%0d bad=%0d want %0d 0",
               len, got_q.size(), word_errs(), (len + 1) / 2);
    end
    tests_run++;
    if ({n_short, n_long, n_sof, n_done} !== {32'd1, 32'd0, 32'd0,
        32'd1}) begin
      tests_failed++;
      $display("FAIL short%0d_flags: got s=%0d l=%0d sof=%0d done=%0d want 1 0 0 1",
               len, n_short, n_long, n_sof, n_done);
    end
    test_next_ok($sformatf("short%0d", len));
  endtask

  task automatic test_long();
    ready_pct = 70;
    gap_pct = 10;
    clear_sb();
    fill(BC + 4, 1'b0);
    build_expected(BC);
    send_frame(-1);
    drain();
    tests_run++;
    if (got_q.size() !== 256 || word_errs() !== 0) begin
      tests_failed++;
      $display("FAIL long_words: got n=%0d bad=%0d want 256 0",
               got_q.size(), word_errs());
    end
    tests_run++;
    if ({n_short, n_long, n_sof, n_done} !== {32'd0, 32'd1, 32'd4,
        32'd1}) begin
      tests_failed++;
      $display("FAIL long_flags: got s=%0d l=%0d sof=%0d done=%0d want 0 1 4 1",
               n_short, n_long, n_sof, n_done);
    end
    test_next_ok("long");
  endtask

  task automatic test_reset_mid();
    ready_pct = 60;
    gap_pct = 0;
    clear_sb();
    fill(200, 1'b0);
    send_frame(-1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({tready, m_valid, m_data, m_last, m_user, err_short,
         err_long, err_sof, frame_done} !== 24'h0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got v=%b d=%h tr=%b want all 0",
               m_valid, m_data, tready);
    end
    rst = 1'b0;
    test_next_ok("midrst");
    tests_run++;
    if (n_done !== 1 || got_q.size() == 0 || got_q[0][16] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_frame: got done=%0d n=%0d want 1 256",
               n_done, got_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    tvalid = 1'b0;
    tdata = '0;
    tuser = 1'b0;
    tlast = 1'b0;
    test_reset();
    test_full_frame();
    test_stall();
    test_short(100);
    test_short(101);
    test_long();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
